timer_counter: RTL and testbench

//  Memory-mapped countdown timer; the responder on the TC0/TC1 ports of the data-side bridge.
//  - Decodes word offsets 0x0/0x4/0x8 from the bridge-supplied address.
//  - Counts PRESET down to 0 and raises an interrupt request to the CP0 HWInt lines.
//  - Two instances sit in the top level (TC0 at 0x7F00, TC1 at 0x7F10); the bridge gates WE per instance.

---
 rtl/timer_counter_pkg.sv | 27 ++
 rtl/timer_counter.sv | 111 +++++++++++
 tb/tb_timer_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the countdown timer: register offsets, FSM encodings,
// MODE codes and the timer address windows also used by the bus bridge.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC0_END  = 32'h0000_7F0B;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TC1_END  = 32'h0000_7F1B;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a 4-state
// count FSM and a level interrupt request gated by CTRL.IM.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] preset_reg;
  logic [DATA_W-1:0] count_reg;
  tc_state_t         state_reg;
  logic              irq_flag_reg;

  logic [1:0] offset;
  logic       ctrl_wr;
  logic       preset_wr;
  logic       reg_wr;
  logic       en;
  logic       im;
  logic [1:0] mode;
  logic       unused_addr;

  assign offset      = Addr[3:2];
  assign ctrl_wr     = WE && (offset == OFF_CTRL);
  assign preset_wr   = WE && (offset == OFF_PRESET);
  assign reg_wr      = ctrl_wr || preset_wr;
  assign en          = ctrl_reg[CTRL_EN];
  assign mode        = ctrl_reg[2:1];
  assign im          = ctrl_reg[CTRL_IM];
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  // A one-shot completion clears EN, unless a bus write lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg   <= '0;
      preset_reg <= '0;
    end else begin
      if (ctrl_wr)
        ctrl_reg <= Din[CTRL_W-1:0];
      else if (!reg_wr && state_reg == ST_INT && mode != MODE_AUTO)
        ctrl_reg[CTRL_EN] <= 1'b0;
      if (preset_wr)
        preset_reg <= Din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else if (reg_wr) begin
      state_reg    <= ST_IDLE;
      irq_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en)
            state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          count_reg <= preset_reg;
          state_reg <= ST_CNT;
        end
        ST_CNT: begin
          // Terminal count at 1 (or 0) so COUNT never wraps below zero.
          if (!en) begin
            state_reg <= ST_IDLE;
          end else if (count_reg > ONE) begin
            count_reg <= count_reg - ONE;
          end else begin
            count_reg    <= '0;
            irq_flag_reg <= 1'b1;
            state_reg    <= ST_INT;
          end
        end
        ST_INT: begin
          state_reg <= ST_IDLE;
          if (mode == MODE_AUTO)
            irq_flag_reg <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (offset)
      OFF_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl_reg};
      OFF_PRESET: Dout = preset_reg;
      OFF_COUNT:  Dout = count_reg;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_reg & im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios followed by random bus traffic,
// checked against a timeline model of each countdown run.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  // Reference state: registers plus the edge index at which the current run started.
  logic [3:0]  m_ctrl   = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count  = '0;
  bit          m_irq    = 1'b0;
  bit          m_run    = 1'b0;
  longint      m_start  = 0;
  longint      cyc      = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // A run started at edge S loads at S+1, interrupts at S+max(P,1)+1 and ends one edge later.
  task automatic model_edge(input bit rst_i, input bit we_i, input logic [1:0] off, input logic [31:0] d);
    longint j;
    longint f;
    cyc++;
    if (rst_i) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_irq = 1'b0; m_run = 1'b0;
    end else if (we_i && off == 2'd0) begin
      m_ctrl = d[3:0]; m_run = 1'b0; m_irq = 1'b0;
    end else if (we_i && off == 2'd1) begin
      m_preset = d; m_run = 1'b0; m_irq = 1'b0;
    end else if (!m_run) begin
      if (m_ctrl[0]) begin
        m_run = 1'b1;
        m_start = cyc;
      end
    end else begin
      j = cyc - m_start;
      f = ((m_preset == 0) ? 64'd1 : longint'(m_preset)) + 1;
      if (j < f) begin
        m_count = m_preset - 32'(j - 1);
      end else if (j == f) begin
        m_count = '0;
        m_irq = 1'b1;
      end else begin
        m_run = 1'b0;
        if (m_ctrl[2:1] == 2'd1) m_irq = 1'b0;
        else m_ctrl[0] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit rst_i, input bit we_i, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = off;
    reset = rst_i; WE = we_i; Addr = a; Din = d;
    @(posedge clk);
    model_edge(rst_i, we_i, off, d);
    #1;
    reset = 1'b0; WE = 1'b0;
    Addr = $urandom;
    Addr[3:2] = 2'd0; #1; check("ctrl", Dout, {28'b0, m_ctrl});
    Addr[3:2] = 2'd1; #1; check("preset", Dout, m_preset);
    Addr[3:2] = 2'd2; #1; check("count", Dout, m_count);
    Addr[3:2] = 2'd3; #1; check("unmapped", Dout, 32'h0);
    check("irq", {31'b0, IRQ}, {31'b0, m_irq & m_ctrl[3]});
    $display("cyc=%0d rst=%0b we=%0b off=%0d din=0x%08h irq=%0b count=0x%08h",
             cyc, rst_i, we_i, off, d, IRQ, m_count);
  endtask

  initial begin
    int n;
    int p1;
    int p2;
    logic [31:0] r;
    reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0;

    // Reset and idle reads
    cycle(1, 0, 2'd0, 32'h0);
    cycle(0, 0, 2'd0, 32'h0);

    // One-shot with interrupt: latency from CTRL write to IRQ
    cycle(0, 1, 2'd1, 32'd5);
    cycle(0, 1, 2'd0, 32'h9);
    n = 0;
    while (n < 20 && IRQ !== 1'b1) begin
      cycle(0, 0, 2'd2, 32'h0);
      n++;
    end
    check("irq_latency", 32'(n), 32'd7);
    repeat (3) cycle(0, 0, 2'd0, 32'h0);
    cycle(0, 1, 2'd0, 32'h0);

    // Auto-reload: pulse spacing
    cycle(0, 1, 2'd1, 32'd3);
    cycle(0, 1, 2'd0, 32'hB);
    p1 = -1; p2 = -1;
    for (int i = 0; i < 25; i++) begin
      cycle(0, 0, 2'd0, 32'h0);
      if (IRQ === 1'b1) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
    end
    check("reload_period", 32'(p2 - p1), 32'd6);
    cycle(0, 1, 2'd0, 32'h0);

    // PRESET=0, IRQ masked
    cycle(0, 1, 2'd1, 32'd0);
    cycle(0, 1, 2'd0, 32'h1);
    repeat (5) cycle(0, 0, 2'd0, 32'h0);

    // Stop mid-count, then writes to read-only offsets
    cycle(0, 1, 2'd1, 32'h40);
    cycle(0, 1, 2'd0, 32'h1);
    repeat (2) cycle(0, 0, 2'd0, 32'h0);
    cycle(0, 1, 2'd0, 32'h0);
    check("count_held", m_count, 32'h40);
    cycle(0, 1, 2'd2, 32'h1234);
    cycle(0, 1, 2'd3, 32'hFFFF_FFFF);

    // Write lands on the same edge as the interrupt
    cycle(0, 1, 2'd1, 32'd2);
    cycle(0, 1, 2'd0, 32'h9);
    repeat (3) cycle(0, 0, 2'd0, 32'h0);
    cycle(0, 1, 2'd0, 32'h8);
    check("collision_irq", {31'b0, IRQ}, 32'h0);

    // Reset mid-count
    cycle(0, 1, 2'd1, 32'h20);
    cycle(0, 1, 2'd0, 32'h9);
    repeat (4) cycle(0, 0, 2'd0, 32'h0);
    cycle(1, 0, 2'd0, 32'h0);
    cycle(0, 0, 2'd0, 32'h0);

    // Random bus traffic
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 63);
      if (n < 2) begin
        cycle(1, 0, 2'd0, 32'h0);
      end else if (n < 10) begin
        r = $urandom;
        if (n < 8) r[0] = 1'b1;
        cycle(0, 1, 2'd0, r);
      end else if (n < 14) begin
        cycle(0, 1, 2'd1, 32'($urandom_range(0, 6)));
      end else if (n < 16) begin
        r = $urandom;
        cycle(0, 1, (n == 14) ? 2'd2 : 2'd3, r);
      end else begin
        cycle(0, 0, 2'd0, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
